// File: rtl/rename_map_if.sv
// rename_map_if: rename, freelist and commit signals between the rename map and its neighbours
interface rename_map_if #(
  parameter int ARCH   = 32,
  parameter int PHYS   = 64,
  parameter int RENAME = 4,
  parameter int COMMIT = 4
);
  localparam int ARCH_W = $clog2(ARCH);
  localparam int TAG    = $clog2(PHYS);
  logic                           flush_;
  logic [RENAME-1:0]              ren_;
  logic [RENAME-1:0]              dst_v_;
  logic [RENAME-1:0][ARCH_W-1:0]  src1;
  logic [RENAME-1:0][ARCH_W-1:0]  src2;
  logic [RENAME-1:0][ARCH_W-1:0]  dst;
  logic [RENAME-1:0][TAG-1:0]     fl_rd;
  logic [RENAME-1:0]              fl_v;
  logic [RENAME-1:0]              fl_re_;
  logic                           stall;
  logic [RENAME-1:0]              ren_v;
  logic [RENAME-1:0][TAG-1:0]     ps1;
  logic [RENAME-1:0][TAG-1:0]     ps2;
  logic [RENAME-1:0][TAG-1:0]     pd;
  logic [RENAME-1:0][TAG-1:0]     ppd;
  logic [COMMIT-1:0]              commit_;
  logic [COMMIT-1:0][ARCH_W-1:0]  cmt_dst;
  logic [COMMIT-1:0][TAG-1:0]     cmt_pd;
  logic [COMMIT-1:0][TAG-1:0]     cmt_ppd;
  logic [COMMIT-1:0]              fl_we_;
  logic [COMMIT-1:0][TAG-1:0]     fl_wd;
  modport master (
    output flush_, ren_, dst_v_, src1, src2, dst, fl_rd, fl_v, commit_, cmt_dst, cmt_pd, cmt_ppd,
    input  fl_re_, stall, ren_v, ps1, ps2, pd, ppd, fl_we_, fl_wd
  );
  modport slave (
    input  flush_, ren_, dst_v_, src1, src2, dst, fl_rd, fl_v, commit_, cmt_dst, cmt_pd, cmt_ppd,
    output fl_re_, stall, ren_v, ps1, ps2, pd, ppd, fl_we_, fl_wd
  );
endinterface

// File: rtl/rename_map.sv
// rename_map: speculative/committed register map with in-group forwarding, commit and flush recovery
module rename_map #(
  parameter int ARCH   = 32,
  parameter int PHYS   = 64,
  parameter int RENAME = 4,
  parameter int COMMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  rename_map_if.slave  bus
);
  localparam int TW = $clog2(PHYS);
  localparam int CW = $clog2(RENAME + 1);
  localparam int KW = RENAME > 1 ? $clog2(RENAME) : 1;
  logic [TW-1:0]              r_smap [ARCH];
  logic [TW-1:0]              r_cmap [ARCH];
  logic [TW-1:0]              w_smap_nxt [ARCH];
  logic [TW-1:0]              w_cmap_nxt [ARCH];
  logic [RENAME-1:0]          w_wr;
  logic [CW-1:0]              w_n;
  logic [CW-1:0]              w_a;
  logic                       w_stall;
  logic [RENAME-1:0][TW-1:0]  w_ps1, w_ps2, w_pd, w_ppd;
  logic [RENAME-1:0][TW-1:0]  r_ps1, r_ps2, r_pd, r_ppd;
  logic [RENAME-1:0]          r_ren_v;
  logic [COMMIT-1:0]          r_fl_we_;
  logic [COMMIT-1:0][TW-1:0]  r_fl_wd;
  assign w_wr = ~bus.ren_ & ~bus.dst_v_;
  // Later slots see earlier slots' new tags; the last writer in the group owns the map entry.
  always_comb begin
    w_n = '0;
    w_a = '0;
    w_ps1 = '0;
    w_ps2 = '0;
    w_pd = '0;
    w_ppd = '0;
    w_smap_nxt = r_smap;
    for (int i = 0; i < RENAME; i++) begin
      w_a = w_a + CW'(bus.fl_v[i]);
      w_ps1[i] = r_smap[bus.src1[i]];
      w_ps2[i] = r_smap[bus.src2[i]];
      w_ppd[i] = w_wr[i] ? r_smap[bus.dst[i]] : '0;
      for (int j = 0; j < i; j++) begin
        if (w_wr[j] && bus.dst[j] == bus.src1[i]) w_ps1[i] = w_pd[j];
        if (w_wr[j] && bus.dst[j] == bus.src2[i]) w_ps2[i] = w_pd[j];
        if (w_wr[i] && w_wr[j] && bus.dst[j] == bus.dst[i]) w_ppd[i] = w_pd[j];
      end
      w_pd[i] = w_wr[i] ? bus.fl_rd[KW'(w_n)] : '0;
      if (w_wr[i]) w_smap_nxt[bus.dst[i]] = w_pd[i];
      w_n = w_n + CW'(w_wr[i]);
    end
  end
  always_comb begin
    w_cmap_nxt = r_cmap;
    for (int i = 0; i < COMMIT; i++)
      if (!bus.commit_[i]) w_cmap_nxt[bus.cmt_dst[i]] = bus.cmt_pd[i];
  end
  assign w_stall = reset | ~bus.flush_ | (w_n > w_a);
  for (genvar g = 0; g < RENAME; g++) begin : g_re
    assign bus.fl_re_[g] = w_stall | (CW'(g) >= w_n);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ARCH; r++) begin
        r_smap[r] <= TW'(r);
        r_cmap[r] <= TW'(r);
      end
      r_ren_v <= '0;
      r_ps1 <= '0;
      r_ps2 <= '0;
      r_pd <= '0;
      r_ppd <= '0;
      r_fl_we_ <= '1;
      r_fl_wd <= '0;
    end else begin
      r_cmap <= w_cmap_nxt;
      if (!bus.flush_) r_smap <= w_cmap_nxt;
      else if (!w_stall) r_smap <= w_smap_nxt;
      r_ren_v <= w_stall ? '0 : ~bus.ren_;
      r_ps1 <= w_ps1;
      r_ps2 <= w_ps2;
      r_pd <= w_pd;
      r_ppd <= w_ppd;
      r_fl_we_ <= bus.commit_;
      r_fl_wd <= bus.cmt_ppd;
    end
  end
  assign bus.stall = w_stall;
  assign bus.ren_v = r_ren_v;
  assign bus.ps1 = r_ps1;
  assign bus.ps2 = r_ps2;
  assign bus.pd = r_pd;
  assign bus.ppd = r_ppd;
  assign bus.fl_we_ = r_fl_we_;
  assign bus.fl_wd = r_fl_wd;
endmodule

// File: tb/tb_rename_map.sv
// tb_rename_map: directed and random stimulus against a sequential-renaming reference model
module tb_rename_map;
  localparam int ARCH = 32, PHYS = 64, RENAME = 4, COMMIT = 4;
  localparam int AW = $clog2(ARCH), TW = $clog2(PHYS);
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0, n_pass = 0;
  int smap [ARCH];
  int cmap [ARCH];
  int e_ps1 [RENAME];
  int e_ps2 [RENAME];
  int e_pd [RENAME];
  int e_ppd [RENAME];
  int e_fl_wd [COMMIT];
  logic [RENAME-1:0] e_ren_v;
  logic [COMMIT-1:0] e_fl_we_;
  bit e_rst;
  always #5 clk = ~clk;
  rename_map_if #(.ARCH(ARCH), .PHYS(PHYS), .RENAME(RENAME), .COMMIT(COMMIT)) bus ();
  rename_map #(.ARCH(ARCH), .PHYS(PHYS), .RENAME(RENAME), .COMMIT(COMMIT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  task automatic chk(input string tag, input int got, input int exp_v);
    n_chk++;
    if (got == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
  endtask
  task automatic idle();
    bus.flush_ = 1'b1;
    bus.ren_ = '1;
    bus.dst_v_ = '1;
    bus.fl_v = '1;
    bus.commit_ = '1;
    for (int i = 0; i < RENAME; i++) begin
      bus.src1[i] = '0;
      bus.src2[i] = '0;
      bus.dst[i] = '0;
      bus.fl_rd[i] = TW'(ARCH + i);
    end
    for (int i = 0; i < COMMIT; i++) begin
      bus.cmt_dst[i] = '0;
      bus.cmt_pd[i] = '0;
      bus.cmt_ppd[i] = '0;
    end
  endtask
  // Model renames the group one slot at a time against a scratch copy of the map.
  task automatic step();
    int tmp [ARCH];
    int n, a, k;
    bit st;
    logic [RENAME-1:0] ere;
    #1;
    n = 0;
    a = 0;
    for (int i = 0; i < RENAME; i++) begin
      if (!bus.ren_[i] && !bus.dst_v_[i]) n++;
      if (bus.fl_v[i]) a++;
    end
    st = reset || !bus.flush_ || n > a;
    chk("stall", int'(bus.stall), int'(st));
    for (int i = 0; i < RENAME; i++) ere[i] = st || i >= n;
    chk("fl_re_", int'(bus.fl_re_), int'(ere));
    tmp = smap;
    k = 0;
    for (int i = 0; i < RENAME; i++) begin
      e_ps1[i] = tmp[bus.src1[i]];
      e_ps2[i] = tmp[bus.src2[i]];
      e_pd[i] = 0;
      e_ppd[i] = 0;
      if (!bus.ren_[i] && !bus.dst_v_[i]) begin
        e_ppd[i] = tmp[bus.dst[i]];
        e_pd[i] = int'(bus.fl_rd[k]);
        k++;
        tmp[bus.dst[i]] = e_pd[i];
      end
      e_ren_v[i] = !st && !bus.ren_[i];
    end
    for (int i = 0; i < COMMIT; i++) begin
      if (!bus.commit_[i]) cmap[bus.cmt_dst[i]] = int'(bus.cmt_pd[i]);
      e_fl_wd[i] = int'(bus.cmt_ppd[i]);
    end
    e_fl_we_ = bus.commit_;
    e_rst = reset;
    if (reset) begin
      for (int r = 0; r < ARCH; r++) begin
        smap[r] = r;
        cmap[r] = r;
      end
      e_ren_v = '0;
      e_fl_we_ = '1;
      for (int i = 0; i < RENAME; i++) begin
        e_ps1[i] = 0;
        e_ps2[i] = 0;
        e_pd[i] = 0;
        e_ppd[i] = 0;
      end
      for (int i = 0; i < COMMIT; i++) e_fl_wd[i] = 0;
    end else if (!bus.flush_) smap = cmap;
    else if (!st) smap = tmp;
    @(posedge clk);
    #1;
    chk("ren_v", int'(bus.ren_v), int'(e_ren_v));
    chk("fl_we_", int'(bus.fl_we_), int'(e_fl_we_));
    for (int i = 0; i < RENAME; i++)
      if (e_ren_v[i] || e_rst) begin
        chk($sformatf("ps1[%0d]", i), int'(bus.ps1[i]), e_ps1[i]);
        chk($sformatf("ps2[%0d]", i), int'(bus.ps2[i]), e_ps2[i]);
        chk($sformatf("pd[%0d]", i), int'(bus.pd[i]), e_pd[i]);
        chk($sformatf("ppd[%0d]", i), int'(bus.ppd[i]), e_ppd[i]);
      end
    for (int i = 0; i < COMMIT; i++) chk($sformatf("fl_wd[%0d]", i), int'(bus.fl_wd[i]), e_fl_wd[i]);
  endtask
  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    idle();
    bus.ren_ = 4'b1110;
    bus.dst_v_ = 4'b1110;
    bus.dst[0] = 5'd5;
    bus.src1[0] = 5'd5;
    bus.fl_rd[0] = 6'd32;
    step();
    chk("t1_ren_v", int'(bus.ren_v), 1);
    chk("t1_ps1", int'(bus.ps1[0]), 5);
    chk("t1_pd", int'(bus.pd[0]), 32);
    chk("t1_ppd", int'(bus.ppd[0]), 5);
    idle();
    bus.ren_ = 4'b1100;
    bus.dst_v_ = 4'b1100;
    bus.dst[0] = 5'd3;
    bus.dst[1] = 5'd3;
    bus.src1[1] = 5'd3;
    bus.fl_rd[0] = 6'd40;
    bus.fl_rd[1] = 6'd41;
    step();
    chk("t2_ps1", int'(bus.ps1[1]), 40);
    chk("t2_ppd", int'(bus.ppd[1]), 40);
    chk("t2_pd", int'(bus.pd[1]), 41);
    idle();
    bus.ren_ = 4'b1110;
    bus.src1[0] = 5'd3;
    step();
    chk("t2_smap3", int'(bus.ps1[0]), 41);
    idle();
    bus.ren_ = 4'b1000;
    bus.dst_v_ = 4'b1000;
    bus.dst[0] = 5'd10;
    bus.dst[1] = 5'd11;
    bus.dst[2] = 5'd12;
    bus.fl_v = 4'b0011;
    #1;
    chk("t3_stall", int'(bus.stall), 1);
    chk("t3_fl_re_", int'(bus.fl_re_), 15);
    step();
    chk("t3_ren_v", int'(bus.ren_v), 0);
    idle();
    bus.ren_ = 4'b1000;
    bus.src1[0] = 5'd10;
    bus.src1[1] = 5'd11;
    bus.src1[2] = 5'd12;
    step();
    chk("t3_smap10", int'(bus.ps1[0]), 10);
    chk("t3_smap12", int'(bus.ps1[2]), 12);
    idle();
    bus.commit_ = 4'b1100;
    bus.cmt_dst[0] = 5'd7;
    bus.cmt_dst[1] = 5'd7;
    bus.cmt_pd[0] = 6'd50;
    bus.cmt_pd[1] = 6'd51;
    bus.cmt_ppd[0] = 6'd7;
    bus.cmt_ppd[1] = 6'd50;
    step();
    chk("t4_fl_we_", int'(bus.fl_we_), 12);
    chk("t4_fl_wd0", int'(bus.fl_wd[0]), 7);
    chk("t4_fl_wd1", int'(bus.fl_wd[1]), 50);
    idle();
    bus.ren_ = 4'b1110;
    bus.dst_v_ = 4'b1110;
    bus.dst[0] = 5'd2;
    bus.fl_rd[0] = 6'd44;
    step();
    idle();
    bus.flush_ = 1'b0;
    bus.ren_ = 4'b1110;
    step();
    chk("t5_flush_ren_v", int'(bus.ren_v), 0);
    idle();
    bus.ren_ = 4'b1100;
    bus.src1[0] = 5'd2;
    bus.src1[1] = 5'd7;
    step();
    chk("t5_ps1_r2", int'(bus.ps1[0]), 2);
    chk("t5_ps1_r7", int'(bus.ps1[1]), 51);
    idle();
    bus.ren_ = 4'b1110;
    bus.dst_v_ = 4'b1110;
    bus.dst[0] = 5'd9;
    bus.fl_rd[0] = 6'd45;
    step();
    reset = 1'b1;
    idle();
    bus.ren_ = 4'b1100;
    bus.dst_v_ = 4'b1100;
    bus.dst[0] = 5'd9;
    bus.fl_rd[0] = 6'd46;
    step();
    chk("t6_ren_v", int'(bus.ren_v), 0);
    reset = 1'b0;
    idle();
    bus.ren_ = 4'b1110;
    bus.src1[0] = 5'd9;
    step();
    chk("t6_ps1", int'(bus.ps1[0]), 9);
    for (int c = 0; c < 400; c++) begin
      int nr, nf, lim;
      lim = (c % 2 == 1) ? 7 : ARCH - 1;
      reset = ($urandom_range(0, 49) == 0);
      idle();
      bus.flush_ = ($urandom_range(0, 19) != 0);
      nr = $urandom_range(0, RENAME);
      nf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, RENAME) : RENAME;
      for (int i = 0; i < RENAME; i++) begin
        bus.ren_[i] = (i >= nr);
        bus.fl_v[i] = (i < nf);
        bus.dst_v_[i] = ($urandom_range(0, 3) == 0);
        bus.src1[i] = AW'($urandom_range(0, lim));
        bus.src2[i] = AW'($urandom_range(0, lim));
        bus.dst[i] = AW'($urandom_range(0, lim));
        bus.fl_rd[i] = TW'($urandom_range(ARCH, PHYS - 1));
      end
      for (int i = 0; i < COMMIT; i++) begin
        bus.commit_[i] = ($urandom_range(0, 1) == 1);
        bus.cmt_dst[i] = AW'($urandom_range(0, lim));
        bus.cmt_pd[i] = TW'($urandom_range(0, PHYS - 1));
        bus.cmt_ppd[i] = TW'($urandom_range(0, PHYS - 1));
      end
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
